// File: rtl/fft_frame_feeder.sv
// Circular PCM sample buffer that bursts N-sample frames into the FFT slave port.
// Build option OVERLAP_50_EN: advance frames by N/2 (50% overlap) instead of N.
module fft_frame_feeder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        curr_nfft,
    input  logic              audio_valid,
    input  logic [DATA_W-1:0] audio_data,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [31:0]       m_axis_tdata,
    output logic              frame_active,
    output logic              frame_start,
    output logic              overrun,
    input  logic              overrun_clr
);
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_W;

    typedef enum logic {IDLE, STREAM} state_t;
    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data;
    logic [PW-1:0] wr_ptr, rd_ptr, frame_base, guard;
    logic [PW-1:0] n_cur, n_lat, hop;
    logic [PW-1:0] rd_cnt, beat_cnt;
    logic          rd_pend;
    logic [15:0]   sb [2];
    logic          sb_head, sb_tail;
    logic [1:0]    sb_cnt;
    logic [15:0]   real16;
    logic          wr_ok, wr_en, drop;
    logic          trigger, issue, pop, last_pop;

    always_comb begin
        unique case (curr_nfft)
            5'd9:    n_cur = PW'(512);
            5'd8:    n_cur = PW'(256);
            5'd7:    n_cur = PW'(128);
            default: n_cur = PW'(1024);
        endcase
    end

`ifdef OVERLAP_50_EN
    assign hop = n_cur >> 1;
`else
    assign hop = n_cur;
`endif

    // guard marks the oldest sample that must survive until it is streamed
    assign wr_ok    = (wr_ptr - guard) < DEPTH;
    assign wr_en    = audio_valid && wr_ok;
    assign drop     = audio_valid && !wr_ok;
    assign trigger  = (state_q == IDLE) && ((wr_ptr - frame_base) >= n_cur);
    assign pop      = m_axis_tvalid && m_axis_tready;
    assign last_pop = pop && (beat_cnt == n_lat - PW'(1));

    // keep skid entries plus the read in flight within two after this cycle's pop
    assign issue = (state_q == STREAM) && (rd_cnt != n_lat) &&
                   ((3'(sb_cnt) + 3'(rd_pend) - 3'(pop)) < 3'd2);

    assign real16        = 16'($signed(rd_data));
    assign m_axis_tvalid = (sb_cnt != 2'd0);
    assign m_axis_tdata  = m_axis_tvalid ? {16'h0000, sb[sb_head]} : 32'h0;
    assign frame_active  = (state_q == STREAM);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (trigger) state_d = STREAM;
            STREAM:  if (last_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= audio_data;
        if (issue) rd_data <= mem[rd_ptr[ADDR_W-1:0]];
        if (rd_pend) sb[sb_tail] <= real16;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            frame_base  <= '0;
            guard       <= '0;
            n_lat       <= '0;
            rd_cnt      <= '0;
            beat_cnt    <= '0;
            rd_pend     <= 1'b0;
            sb_head     <= 1'b0;
            sb_tail     <= 1'b0;
            sb_cnt      <= 2'd0;
            frame_start <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_start <= trigger;
            rd_pend     <= issue;
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (drop) overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
            if (trigger) begin
                n_lat      <= n_cur;
                rd_ptr     <= frame_base;
                guard      <= frame_base;
                frame_base <= frame_base + hop;
                rd_cnt     <= '0;
                beat_cnt   <= '0;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PW'(1);
                rd_cnt <= rd_cnt + PW'(1);
            end
            if (pop) begin
                sb_head  <= ~sb_head;
                beat_cnt <= beat_cnt + PW'(1);
            end
            if (rd_pend) sb_tail <= ~sb_tail;
            sb_cnt <= sb_cnt + 2'(rd_pend) - 2'(pop);
            if (last_pop) guard <= frame_base;
        end
    end
endmodule

// File: tb/tb_fft_frame_feeder.sv
// Randomized bench for fft_frame_feeder against a sample-index frame model.
// Honours OVERLAP_50_EN in the model's frame hop.
module tb_fft_frame_feeder;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [4:0]        curr_nfft;
    logic              audio_valid;
    logic [DATA_W-1:0] audio_data;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [31:0]       m_axis_tdata;
    logic              frame_active;
    logic              frame_start;
    logic              overrun;
    logic              overrun_clr;

    always #5 clk = ~clk;

    fft_frame_feeder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .curr_nfft(curr_nfft),
        .audio_valid(audio_valid),
        .audio_data(audio_data),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .frame_active(frame_active),
        .frame_start(frame_start),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    int n_chk, n_err, cyc, sent, cap, tr_mode, fs_age;
    int last_beat_cyc, fa_fall_cyc;
    bit stalled, fa_prev;
    logic [31:0] held;
    logic [15:0] acc[$];
    logic [31:0] beats[$];
    logic [31:0] exp_q[$];
    int bcyc[$];
    int starts[$];
    int exp_starts[$];
    int nseq[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, want, cyc);
        end
    endtask

    function automatic int hop_of(input int n);
`ifdef OVERLAP_50_EN
        return n / 2;
`else
        return n;
`endif
    endfunction

    task automatic tick();
        case (tr_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
        if (stalled) begin
            chk("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
            chk("stall_tdata", m_axis_tdata, held);
        end
        if (m_axis_tvalid) chk("tvalid_in_frame", 32'(frame_active), 32'd1);
        if (fs_age < 3) fs_age++;
        if (fs_age == 1) chk("lat_early", 32'(m_axis_tvalid), 32'd0);
        if (fs_age == 2) chk("lat_first", 32'(m_axis_tvalid), 32'd1);
        if (frame_start) begin
            starts.push_back(beats.size());
            fs_age = 0;
        end
        if (fa_prev && !frame_active) fa_fall_cyc = cyc;
        fa_prev = frame_active;
        if (m_axis_tvalid && m_axis_tready) begin
            beats.push_back(m_axis_tdata);
            bcyc.push_back(cyc);
            last_beat_cyc = cyc;
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        held = m_axis_tdata;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear();
        acc.delete();
        beats.delete();
        bcyc.delete();
        starts.delete();
        sent = 0;
        cap = 1 << 30;
        fs_age = 3;
        stalled = 1'b0;
        fa_prev = 1'b0;
    endtask

    task automatic do_reset();
        audio_valid = 1'b0;
        overrun_clr = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata", m_axis_tdata, 32'd0);
        chk("rst_active", 32'(frame_active), 32'd0);
        chk("rst_start", 32'(frame_start), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        clear();
    endtask

    task automatic feed(input int n, input int gap, input bit ramp);
        logic [15:0] s;
        for (int i = 0; i < n; i++) begin
            s = ramp ? 16'(sent) : 16'($urandom);
            sent++;
            audio_data = s;
            audio_valid = 1'b1;
            if (acc.size() < cap) acc.push_back(s);
            tick();
            audio_valid = 1'b0;
            for (int g = 1; g < gap; g++) tick();
        end
    endtask

    // Frame j covers accepted samples [base_j, base_j + N_j); base advances by hop
    task automatic build_exp();
        int base, total, j, n;
        exp_q.delete();
        exp_starts.delete();
        base = 0;
        total = 0;
        j = 0;
        n = nseq[0];
        while (acc.size() - base >= n) begin
            exp_starts.push_back(total);
            for (int k = 0; k < n; k++)
                exp_q.push_back({16'h0000, acc[base+k]});
            total += n;
            base += hop_of(n);
            j++;
            n = (j < nseq.size()) ? nseq[j] : nseq[nseq.size()-1];
        end
    endtask

    task automatic drain();
        int k;
        build_exp();
        k = 0;
        while (beats.size() < exp_q.size() && k < 20000) begin
            tick();
            k++;
        end
        chk("drain_done", 32'(beats.size() >= exp_q.size()), 32'd1);
        repeat (16) tick();
    endtask

    task automatic compare(input string tag);
        int m, bad, e0;
        build_exp();
        chk({tag, "_nbeats"}, 32'(beats.size()), 32'(exp_q.size()));
        chk({tag, "_nframes"}, 32'(starts.size()), 32'(exp_starts.size()));
        m = (starts.size() < exp_starts.size()) ? starts.size() : exp_starts.size();
        for (int k = 0; k < m; k++)
            chk({tag, "_fpos"}, 32'(starts[k]), 32'(exp_starts[k]));
        m = (beats.size() < exp_q.size()) ? beats.size() : exp_q.size();
        bad = 0;
        for (int k = 0; k < m && bad < 4; k++) begin
            e0 = n_err;
            chk({tag, "_data"}, beats[k], exp_q[k]);
            if (n_err != e0) bad++;
        end
    endtask

    initial begin
        int k;
        n_chk = 0;
        n_err = 0;
        cyc = 0;
        rst = 1'b0;
        audio_valid = 1'b0;
        audio_data = '0;
        curr_nfft = 5'd7;
        m_axis_tready = 1'b0;
        overrun_clr = 1'b0;
        tr_mode = 1;
        last_beat_cyc = 0;
        fa_fall_cyc = 0;
        clear();
        @(negedge clk);

        // 128-point ramp, tready high
        do_reset();
        curr_nfft = 5'd7;
        tr_mode = 1;
        nseq.delete();
        nseq.push_back(128);
        feed(128, 4, 1'b1);
        drain();
        compare("t1");
        if (bcyc.size() == 128)
            chk("t1_b2b", 32'(bcyc[127] - bcyc[0]), 32'd127);
        chk("t1_fafall", 32'(fa_fall_cyc - last_beat_cyc), 32'd1);

        // 1024-point, random backpressure
        do_reset();
        curr_nfft = 5'd10;
        tr_mode = 2;
        nseq.delete();
        nseq.push_back(1024);
        feed(3000, 4, 1'b1);
        drain();
        compare("t2");
        chk("t2_overrun", 32'(overrun), 32'd0);

        // overrun with a stalled frame
        do_reset();
        curr_nfft = 5'd8;
        tr_mode = 0;
        nseq.delete();
        nseq.push_back(256);
        cap = DEPTH;
        feed(DEPTH, 1, 1'b0);
        chk("t3_ovr_pre", 32'(overrun), 32'd0);
        feed(1, 1, 1'b0);
        chk("t3_ovr_set", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("t3_ovr_clr", 32'(overrun), 32'd0);
        overrun_clr = 1'b1;
        feed(1, 1, 1'b0);
        overrun_clr = 1'b0;
        chk("t3_set_wins", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("t3_ovr_clr2", 32'(overrun), 32'd0);
        tr_mode = 1;
        cap = 1 << 30;
        drain();
        feed(256, 1, 1'b0);
        drain();
        compare("t3");

        // frame size change mid-frame
        do_reset();
        curr_nfft = 5'd9;
        tr_mode = 2;
        nseq.delete();
        nseq.push_back(512);
        nseq.push_back(128);
        feed(512, 2, 1'b0);
        k = 0;
        while (beats.size() < 100 && k < 5000) begin
            tick();
            k++;
        end
        curr_nfft = 5'd7;
        feed(256, 2, 1'b0);
        drain();
        compare("t4");

        // reset mid-frame
        do_reset();
        curr_nfft = 5'd8;
        tr_mode = 1;
        nseq.delete();
        nseq.push_back(256);
        feed(256, 4, 1'b0);
        k = 0;
        while (beats.size() < 40 && k < 2000) begin
            tick();
            k++;
        end
        chk("t5_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t5_tdata", m_axis_tdata, 32'd0);
        chk("t5_active", 32'(frame_active), 32'd0);
        chk("t5_start", 32'(frame_start), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        clear();
        feed(256, 4, 1'b0);
        drain();
        compare("t5");

        // unmapped curr_nfft defaults to 1024
        do_reset();
        curr_nfft = 5'($urandom_range(11, 31));
        tr_mode = 1;
        nseq.delete();
        nseq.push_back(1024);
        feed(1100, 1, 1'b0);
        drain();
        compare("t6");

        // 128-point over 256 ramp samples (overlapping frames when enabled)
        do_reset();
        curr_nfft = 5'd7;
        tr_mode = 1;
        nseq.delete();
        nseq.push_back(128);
        feed(256, 4, 1'b1);
        drain();
        compare("t7");
        chk("t7_fafall", 32'(fa_fall_cyc - last_beat_cyc), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fft_frame_feeder.md
Name: fft_frame_feeder

Overview:
Upstream feeder for the FFT core's slave data channel. It collects signed PCM samples arriving at audio rate into a circular sample RAM. Once a full frame of N = 2^curr_nfft new samples is available, it streams that frame as an AXI-Stream burst into the FFT input, which the downstream TLAST generator counts.

Parameters:
DATA_W, 16, PCM sample width (signed two's complement)
ADDR_W, 11, sample RAM address width; DEPTH = 2^ADDR_W = 2048 (must be >= 2x max frame of 1024)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
curr_nfft  input  5  log2 frame size; 10/9/8/7 → 1024/512/256/128, any other value → 1024
audio_valid  input  1  one-cycle strobe, new sample on audio_data
audio_data  input  DATA_W  signed PCM sample
m_axis_tvalid  output  1  FFT input data valid
m_axis_tready  input  1  FFT input ready
m_axis_tdata  output  32  {16'h0000 imag, real}; real = audio_data sign-extended/truncated to 16 bits
frame_active  output  1  high from frame trigger until last beat accepted
frame_start  output  1  one-cycle pulse on frame trigger
overrun  output  1  sticky; a sample was dropped
overrun_clr  input  1  synchronous clear of overrun

Behaviour:
- Clock/reset: single clock clk; rst asynchronous active-high. Reset mid-operation aborts any frame and discards all buffered samples: wr_ptr = rd_ptr = frame_base = guard = 0, FSM IDLE, all outputs 0.
- Pointers are ADDR_W+1 bits (extra wrap bit); RAM indexed by low ADDR_W bits. RAM is single-clock, one write port, synchronous read (1-cycle latency).
- Write side:
  - occupancy = wr_ptr − guard.
  - On audio_valid with occupancy < DEPTH: write mem[wr_ptr], wr_ptr++.
  - On audio_valid with occupancy == DEPTH: drop the sample, set overrun, leave wr_ptr unchanged.
  - overrun_clr clears overrun. If a drop occurs in the same cycle as overrun_clr, the set wins.
- guard: equals frame_base in IDLE; equals the base of the in-flight frame in STREAM.
- FSM:
  - IDLE: when (wr_ptr − frame_base) >= N_cur, where N_cur = 2^curr_nfft (mapped) sampled this cycle:
    - latch N_lat = N_cur, rd_ptr = frame_base, guard = frame_base, frame_base += hop (hop = N_lat).
    - pulse frame_start, set frame_active, go STREAM.
  - STREAM: issue RAM reads at rd_ptr into a 2-entry output skid buffer.
    - Issue a read only when the buffer plus in-flight read ≤ 2 entries.
    - Each beat accepted (tvalid && tready) pops the buffer. After N_lat beats accepted, clear frame_active, set guard = frame_base, go IDLE.
  - An audio_valid write in the trigger cycle is allowed and counts toward the next frame.
- Latency and handshake:
  - First tvalid asserts 2 cycles after frame_start.
  - With tready held high, beats are back-to-back with no bubbles through beat N_lat.
  - tdata/tvalid must not change while tvalid && !tready.
  - tvalid never asserts outside STREAM. No beat beyond N_lat is emitted.
- curr_nfft changes take effect only at the next trigger; a frame in flight keeps N_lat.
- Samples are emitted in arrival order, oldest first. Pointer wrap across DEPTH is transparent.

Optional Feature:
OVERLAP_50_EN: when defined, hop = N_lat/2 (50% frame overlap). A frame triggers after N new samples for the first frame, then every N/2 samples, and re-reads the last N/2 samples of the previous frame. When undefined, hop = N_lat (no overlap). The occupancy/guard protection is identical in both cases.

Test Plan:
- rst, curr_nfft=7, feed ramp 0..127 (one sample per 4 clk), tready=1 → one frame_start; 128 beats, real = 0..127, imag = 0, contiguous; frame_active falls after beat 127.
- curr_nfft=10, 3000 ramp samples, tready toggling 50% random → exactly 2 frames (0..1023, 1024..2047), no loss/duplication, tdata stable during stalls.
- curr_nfft=8, tready=0 held, feed 2048 samples then 1 more → overrun=1 on sample 2048 and that sample is dropped; overrun_clr → overrun=0.
- curr_nfft changed 9→7 mid-frame → current frame still 512 beats; next frame 128 beats.
- rst pulsed mid-frame (beat 40 of 256) → tvalid=0 within the same cycle, all outputs 0; next frame restarts with the first sample after reset.
- OVERLAP_50_EN, curr_nfft=7, ramp 0..255 → frames start at samples 0, 64, 128 (each 128 beats, overlapping by 64).
